// File: rtl/projectile_engine_if.sv
// Projectile engine bus: per-channel fire/hit controls, owner position, projectile status and the
// pixel lookup path.
//   master: drives fire, face_right, hit_ack, owner_x, draw_x, draw_y
//   slave : drives active, proj_x, ready, cd_level, pix_on, pix_ch, sprite_addr
interface projectile_engine_if #(
  parameter int unsigned NumCh = 2,
  parameter int unsigned XW    = 10
);
  logic [NumCh-1:0]    fire;
  logic [NumCh-1:0]    face_right;
  logic [NumCh-1:0]    hit_ack;
  logic [NumCh*XW-1:0] owner_x;
  logic [NumCh-1:0]    active;
  logic [NumCh*XW-1:0] proj_x;
  logic [NumCh-1:0]    ready;
  logic [NumCh*5-1:0]  cd_level;
  logic [XW-1:0]       draw_x;
  logic [XW-1:0]       draw_y;
  logic                pix_on;
  logic [2:0]          pix_ch;
  logic [31:0]         sprite_addr;

  modport master (
    output fire, face_right, hit_ack, owner_x, draw_x, draw_y,
    input  active, proj_x, ready, cd_level, pix_on, pix_ch, sprite_addr
  );

  modport slave (
    input  fire, face_right, hit_ack, owner_x, draw_x, draw_y,
    output active, proj_x, ready, cd_level, pix_on, pix_ch, sprite_addr
  );
endinterface

// File: rtl/projectile_engine.sv
// Per-player projectile manager with NumCh independent channels.
// Each channel: IDLE -> FLY -> COOL -> IDLE, advancing only on a synchronised frame tick.
// The pixel path maps the current VGA pixel to the owning channel and its sprite SRAM address.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   frame_clk_i vsync-rate strobe, synchronised internally
//   bus         projectile_engine_if.slave (controls, status, pixel lookup)
module projectile_engine #(
  parameter int unsigned NumCh      = 2,
  parameter int unsigned XW         = 10,
  parameter int unsigned Speed      = 4,
  parameter int unsigned SpawnOfs   = 100,
  parameter int unsigned ScreenMax  = 739,
  parameter int unsigned YPos       = 300,
  parameter int unsigned HalfW      = 100,
  parameter int unsigned HalfH      = 50,
  parameter int unsigned CdDiv      = 8,
  parameter int unsigned CdMax      = 31,
  parameter logic [31:0] SramBase   = 32'h61A80,
  parameter logic [31:0] SramStride = 32'h668A0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                frame_clk_i,
  projectile_engine_if.slave  bus
);

  // Two extra bits keep spawn/box arithmetic free of wrap-around.
  localparam int unsigned WW   = XW + 2;
  localparam int unsigned DivW = (CdDiv > 1) ? $clog2(CdDiv) : 1;

  localparam logic [WW-1:0]   SpawnOfsW  = WW'(SpawnOfs);
  localparam logic [WW-1:0]   ScreenMaxW = WW'(ScreenMax);
  localparam logic [WW-1:0]   SpeedW     = WW'(Speed);
  localparam logic [WW-1:0]   HalfWW     = WW'(HalfW);
  localparam logic [WW-1:0]   YTopW      = WW'(YPos - HalfH);
  localparam logic [WW-1:0]   YBotW      = WW'(YPos + HalfH - 1);
  localparam logic [XW-1:0]   SpeedX     = XW'(Speed);
  localparam logic [4:0]      CdMax5     = 5'(CdMax);
  localparam logic [DivW-1:0] DivLast    = DivW'(CdDiv - 1);
  localparam logic [31:0]     RowPitch   = 32'(2 * HalfW);

  typedef enum logic [1:0] {StIdle, StFly, StCool} state_e;

  // Frame strobe synchroniser and rising-edge detect.
  logic [2:0] sync_q;
  logic       tick;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[1:0], frame_clk_i};
  end

  assign tick = sync_q[1] & ~sync_q[2];

  logic [WW-1:0] dx_w, dy_w;
  logic          in_y;

  assign dx_w = WW'(bus.draw_x);
  assign dy_w = WW'(bus.draw_y);
  assign in_y = (dy_w >= YTopW) && (dy_w <= YBotW);

  logic [NumCh-1:0] active_v, ready_v, box_hit;
  logic [31:0]      box_addr [NumCh];

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    localparam logic [31:0] ChBase = SramBase + SramStride * 32'(c);

    state_e          st_q, st_d;
    logic [XW-1:0]   x_q, x_d;
    logic            face_q, face_d;
    logic [4:0]      cd_q, cd_d;
    logic [DivW-1:0] div_q, div_d;

    logic            fire, face_in, hit;
    logic [WW-1:0]   own_w, spawn_w, x_w, row_w, col_w;
    logic            spawn_ok, edge_exit, cd_step, act, rdy, in_x;

    assign fire     = bus.fire[c];
    assign face_in  = bus.face_right[c];
    assign hit      = bus.hit_ack[c];
    assign own_w    = WW'(bus.owner_x[c*XW +: XW]);
    assign x_w      = WW'(x_q);

    assign spawn_w  = face_in ? own_w + SpawnOfsW : own_w - SpawnOfsW;
    assign spawn_ok = face_in ? (spawn_w <= ScreenMaxW) : (own_w >= SpawnOfsW);
    assign edge_exit = face_q ? (x_w + SpeedW > ScreenMaxW) : (x_w < SpeedW);
    assign cd_step  = (div_q == DivLast);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st_q   <= StIdle;
        x_q    <= '0;
        face_q <= 1'b0;
        cd_q   <= '0;
        div_q  <= '0;
      end else begin
        st_q   <= st_d;
        x_q    <= x_d;
        face_q <= face_d;
        cd_q   <= cd_d;
        div_q  <= div_d;
      end
    end

    // Next-state logic
    always_comb begin
      st_d = st_q;
      if (tick) begin
        case (st_q)
          StIdle:  if (fire) st_d = spawn_ok ? StFly : StCool;
          StFly:   if (hit || edge_exit) st_d = StCool;
          StCool:  if (cd_q == CdMax5) st_d = StIdle;
          default: st_d = StIdle;
        endcase
      end
    end

    // Datapath: position, facing latch and cooldown counter
    always_comb begin
      x_d    = x_q;
      face_d = face_q;
      cd_d   = cd_q;
      div_d  = div_q;
      if (tick) begin
        case (st_q)
          StIdle: begin
            if (fire) begin
              face_d = face_in;
              cd_d   = 5'd1;
              div_d  = '0;
              // A rejected spawn leaves the old position in place; active stays low.
              if (spawn_ok) x_d = spawn_w[XW-1:0];
            end
          end
          StFly, StCool: begin
            if (st_q == StCool && cd_q == CdMax5) begin
              cd_d  = '0;
              div_d = '0;
            end else begin
              div_d = cd_step ? '0 : div_q + 1'b1;
              if (cd_step && cd_q != CdMax5) cd_d = cd_q + 5'd1;
              if (st_q == StFly && !hit && !edge_exit) begin
                x_d = face_q ? x_q + SpeedX : x_q - SpeedX;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Outputs
    always_comb begin
      act = (st_q == StFly);
      rdy = (st_q == StIdle);
    end

    // Box test; left edge compared as DrawX + HalfW >= x so it never goes negative.
    assign in_x  = (dx_w + HalfWW >= x_w) && (dx_w <= x_w + HalfWW - 1'b1);
    assign row_w = dy_w - YTopW;
    assign col_w = face_q ? dx_w + HalfWW - x_w : x_w + HalfWW - 1'b1 - dx_w;

    assign active_v[c]  = act;
    assign ready_v[c]   = rdy;
    assign box_hit[c]   = act && in_x && in_y;
    assign box_addr[c]  = ChBase + 32'(row_w) * RowPitch + 32'(col_w);

    assign bus.proj_x[c*XW +: XW] = x_q;
    assign bus.cd_level[c*5 +: 5] = cd_q;
  end

  assign bus.active = active_v;
  assign bus.ready  = ready_v;

  // Lowest-index channel wins: scan downward so lower indices overwrite.
  always_comb begin
    bus.pix_on      = 1'b0;
    bus.pix_ch      = '0;
    bus.sprite_addr = '0;
    for (int c = NumCh - 1; c >= 0; c--) begin
      if (box_hit[c]) begin
        bus.pix_on      = 1'b1;
        bus.pix_ch      = 3'(c);
        bus.sprite_addr = box_addr[c];
      end
    end
  end

endmodule

// File: tb/tb_projectile_engine.sv
module tb_projectile_engine;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_clk = 1'b0;

  always #5 clk = ~clk;

  projectile_engine_if #(.NumCh(N), .XW(10)) bus ();

  projectile_engine #(.NumCh(N), .XW(10)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .frame_clk_i (frame_clk),
    .bus         (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit settle = 1'b1;
  bit pix_rand = 1'b0;

  // Reference model: 0 idle, 1 flying, 2 cooling; el = ticks since the shot.
  int m_st[N], m_x[N], m_face[N], m_cd[N], m_el[N];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_st[c] = 0; m_x[c] = 0; m_face[c] = 0; m_cd[c] = 0; m_el[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      int own, sp;
      own = int'(bus.owner_x[c*10 +: 10]);
      if (m_st[c] == 0) begin
        if (bus.fire[c]) begin
          m_face[c] = int'(bus.face_right[c]);
          sp = m_face[c] ? own + 100 : own - 100;
          m_cd[c] = 1;
          m_el[c] = 0;
          if (sp < 0 || sp > 739) m_st[c] = 2;
          else begin m_x[c] = sp; m_st[c] = 1; end
        end
      end else if (m_st[c] == 2 && m_cd[c] == 31) begin
        m_st[c] = 0;
        m_cd[c] = 0;
      end else begin
        m_el[c]++;
        m_cd[c] = (1 + m_el[c] / 8 > 31) ? 31 : 1 + m_el[c] / 8;
        if (m_st[c] == 1) begin
          if (bus.hit_ack[c]) m_st[c] = 2;
          else if (m_face[c] == 1) begin
            if (m_x[c] + 4 > 739) m_st[c] = 2; else m_x[c] += 4;
          end else begin
            if (m_x[c] < 4) m_st[c] = 2; else m_x[c] -= 4;
          end
        end
      end
    end
  endtask

  task automatic model_pix(output int on, output int ch, output longint addr);
    int dx, dy;
    dx = int'(bus.draw_x);
    dy = int'(bus.draw_y);
    on = 0; ch = 0; addr = 0;
    for (int c = 0; c < N; c++) begin
      if (on == 0 && m_st[c] == 1 && dx >= m_x[c] - 100 && dx <= m_x[c] + 99 &&
          dy >= 250 && dy <= 349) begin
        on = 1;
        ch = c;
        addr = 64'h61A80 + c * 64'h668A0 + (dy - 250) * 200 +
               (m_face[c] ? dx - (m_x[c] - 100) : (m_x[c] + 99) - dx);
      end
    end
  endtask

  task automatic compare_all();
    int on, ch;
    longint addr;
    for (int c = 0; c < N; c++) begin
      check($sformatf("active[%0d]", c), bus.active[c], m_st[c] == 1);
      check($sformatf("ready[%0d]", c), bus.ready[c], m_st[c] == 0);
      check($sformatf("proj_x[%0d]", c), bus.proj_x[c*10 +: 10], m_x[c]);
      check($sformatf("cd_level[%0d]", c), bus.cd_level[c*5 +: 5], m_cd[c]);
    end
    model_pix(on, ch, addr);
    check("pix_on", bus.pix_on, on);
    check("pix_ch", bus.pix_ch, ch);
    check("sprite_addr", bus.sprite_addr, addr);
  endtask

  always @(negedge clk) if (rst_n && !settle) compare_all();

  // Pixel sweep biased toward the projectile boxes.
  always @(posedge clk) begin
    if (pix_rand) begin
      int c, px, py;
      #1;
      c = $urandom_range(0, N - 1);
      px = m_x[c] + $urandom_range(0, 220) - 110;
      py = 300 + $urandom_range(0, 120) - 60;
      bus.draw_x = 10'(px < 0 ? 0 : px);
      bus.draw_y = 10'(py);
    end
  end

  task automatic do_tick();
    @(posedge clk); #1;
    settle = 1'b1;
    frame_clk = 1'b1;
    repeat (5) @(posedge clk);
    model_step();
    #1;
    settle = 1'b0;
    frame_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic set_owner(input int c, input int x);
    bus.owner_x[c*10 +: 10] = 10'(x);
  endtask

  initial begin
    bus.fire = '0; bus.face_right = '0; bus.hit_ack = '0; bus.owner_x = '0;
    bus.draw_x = '0; bus.draw_y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", bus.active, 0);
    check("rst_ready", bus.ready, 3);
    check("rst_cd", bus.cd_level, 0);
    check("rst_pix_on", bus.pix_on, 0);
    check("rst_addr", bus.sprite_addr, 0);
    rst_n = 1'b1;
    settle = 1'b0;

    // Both channels spawn at x=300, overlapping; ch0 faces right, ch1 left.
    set_owner(0, 200); set_owner(1, 400);
    bus.face_right = 2'b01;
    bus.fire = 2'b11;
    do_tick();
    bus.fire = '0;
    bus.draw_x = 10'd300; bus.draw_y = 10'd300;
    #1;
    check("t2_spawn_x", bus.proj_x[9:0], 300);
    check("t5_pix_on", bus.pix_on, 1);
    check("t5_pix_ch", bus.pix_ch, 0);
    check("t5_addr", bus.sprite_addr, 32'h61A80 + 50 * 200 + 100);
    repeat (3) do_tick();
    bus.draw_x = 10'd190;
    #1;
    check("t2_move_x", bus.proj_x[9:0], 312);
    check("t2_cd", bus.cd_level[4:0], 1);
    check("ch1_left_x", bus.proj_x[19:10], 288);
    check("ch1_pix_ch", bus.pix_ch, 1);
    check("ch1_addr", bus.sprite_addr, 830197);

    // Asynchronous reset while channel 0 is flying.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t1_active", bus.active, 0);
    check("t1_ready", bus.ready, 3);
    check("t1_cd", bus.cd_level, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Right-edge exit with a simultaneous hit.
    set_owner(0, 536);
    bus.face_right = 2'b01;
    bus.fire = 2'b01;
    do_tick();
    bus.fire = '0;
    repeat (25) do_tick();
    check("t4_pre_x", bus.proj_x[9:0], 736);
    check("t4_pre_active", bus.active[0], 1);
    bus.hit_ack = 2'b01;
    do_tick();
    bus.hit_ack = '0;
    check("t4_active", bus.active[0], 0);
    check("t4_x_frozen", bus.proj_x[9:0], 736);

    // Underflowing spawn on ch1 with fire held through the whole recharge.
    set_owner(1, 50);
    bus.face_right = 2'b00;
    bus.fire = 2'b10;
    do_tick();
    check("t3_active", bus.active[1], 0);
    check("t3_ready", bus.ready[1], 0);
    check("t3_cd", bus.cd_level[9:5], 1);
    begin
      int k;
      for (k = 0; k < 300; k++) begin
        do_tick();
        if (bus.ready[1]) break;
      end
      check("t3_ready_rise", bus.ready[1], 1);
    end
    do_tick();
    check("t6_second_shot", bus.ready[1], 0);
    check("t6_cd", bus.cd_level[9:5], 1);
    bus.fire = '0;

    // Randomised phase.
    pix_rand = 1'b1;
    for (int t = 0; t < 400; t++) begin
      bus.fire = 2'($urandom_range(0, 3));
      bus.face_right = 2'($urandom_range(0, 3));
      bus.hit_ack = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      for (int c = 0; c < N; c++) set_owner(c, $urandom_range(0, 850));
      do_tick();
    end
    pix_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
